// File: rtl/cbfp_stage.sv
// rtl/cbfp_stage.sv - block-floating-point normaliser with ping-pong banks and shared block exponent.
// Optional CBFP_ROUND_EN: round-half-up with saturation plus one extra output register stage.
module cbfp_stage #(
   parameter int IN_W      = 23,
   parameter int OUT_W     = 11,
   parameter int LANES     = 16,
   parameter int BLK_LEN   = 64,
   parameter int MAX_SHIFT = IN_W - OUT_W,
   parameter int EXP_W     = $clog2(IN_W)
) (
   input  logic                         clk,
   input  logic                         rstn,
   input  logic                         valid_in,
   input  logic [LANES-1:0][IN_W-1:0]   din_re,
   input  logic [LANES-1:0][IN_W-1:0]   din_im,
   output logic                         valid_out,
   output logic                         sob_out,
   output logic [EXP_W-1:0]             exp_out,
   output logic [LANES-1:0][OUT_W-1:0]  dout_re,
   output logic [LANES-1:0][OUT_W-1:0]  dout_im
);

   localparam int BEATS = BLK_LEN / LANES;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int SH    = IN_W - OUT_W;
   localparam logic [BW-1:0]    LAST_BEAT = BW'(BEATS - 1);
   localparam logic [EXP_W-1:0] R_MAX     = EXP_W'(IN_W - 1);
   localparam logic [EXP_W-1:0] E_CLAMP   = EXP_W'(MAX_SHIFT);

   typedef enum logic {IDLE, DRAIN} state_t;

   function automatic logic [EXP_W-1:0] rsb(input logic [IN_W-1:0] x);
      logic [EXP_W-1:0] n;
      logic             stop;
      n    = '0;
      stop = 1'b0;
      for (int i = IN_W - 2; i >= 0; i--) begin
         if (!stop && (x[i] == x[IN_W-1])) n = n + 1'b1;
         else stop = 1'b1;
      end
      return n;
   endfunction

   function automatic logic [EXP_W-1:0] min2(input logic [EXP_W-1:0] a, input logic [EXP_W-1:0] b);
      return (a < b) ? a : b;
   endfunction

`ifdef CBFP_ROUND_EN
   localparam logic [IN_W-1:0] RND = IN_W'(1) << (SH - 1);

   // Sign-extend by one bit so the rounding add cannot wrap before saturation.
   function automatic logic [OUT_W-1:0] norm(input logic [IN_W-1:0] x, input logic [EXP_W-1:0] e);
      logic [IN_W-1:0] s;
      logic [IN_W:0]   w;
      logic [OUT_W:0]  q;
      s = x << e;
      w = {s[IN_W-1], s} + {1'b0, RND};
      q = w[IN_W -: OUT_W+1];
      if (q[OUT_W] != q[OUT_W-1])
         return q[OUT_W] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
      return q[OUT_W-1:0];
   endfunction
`else
   // e never exceeds the redundant sign bits, so the top OUT_W bits are the floor result.
   function automatic logic [OUT_W-1:0] norm(input logic [IN_W-1:0] x, input logic [EXP_W-1:0] e);
      logic [IN_W-1:0] s;
      s = x << e;
      return s[IN_W-1 -: OUT_W];
   endfunction
`endif

   logic [LANES-1:0][IN_W-1:0] mem_re_q [2][BEATS];
   logic [LANES-1:0][IN_W-1:0] mem_im_q [2][BEATS];
   logic [EXP_W-1:0]           exp_bank_q [2];
   logic [BW-1:0]              wr_beat_q;
   logic                       wr_bank_q;
   logic [EXP_W-1:0]           run_min_q, beat_min;
   logic                       blk_done;

   state_t        state_q, state_d;
   logic [BW-1:0] rd_beat_q, rd_beat_d;
   logic          rd_bank_q, rd_bank_d;
   logic          pend_q, pend_d;
   logic          drain;

   logic                        v1_q, sob1_q;
   logic [EXP_W-1:0]            exp1_q;
   logic [LANES-1:0][OUT_W-1:0] re1_q, im1_q, y_re, y_im;

   always_comb begin
      beat_min = (wr_beat_q == '0) ? R_MAX : run_min_q;
      for (int k = 0; k < LANES; k++) begin
         beat_min = min2(beat_min, rsb(din_re[k]));
         beat_min = min2(beat_min, rsb(din_im[k]));
      end
   end

   assign blk_done = valid_in && (wr_beat_q == LAST_BEAT);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_beat_q     <= '0;
         wr_bank_q     <= 1'b0;
         run_min_q     <= R_MAX;
         exp_bank_q[0] <= '0;
         exp_bank_q[1] <= '0;
      end else if (valid_in) begin
         run_min_q <= beat_min;
         if (blk_done) begin
            wr_beat_q             <= '0;
            wr_bank_q             <= ~wr_bank_q;
            exp_bank_q[wr_bank_q] <= min2(beat_min, E_CLAMP);
         end else begin
            wr_beat_q <= wr_beat_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (valid_in) begin
         mem_re_q[wr_bank_q][wr_beat_q] <= din_re;
         mem_im_q[wr_bank_q][wr_beat_q] <= din_im;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= IDLE;
         rd_beat_q <= '0;
         rd_bank_q <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         rd_beat_q <= rd_beat_d;
         rd_bank_q <= rd_bank_d;
         pend_q    <= pend_d;
      end
   end

   // Blocks complete and drain in order, so the read bank simply alternates.
   always_comb begin
      state_d   = state_q;
      rd_beat_d = rd_beat_q;
      rd_bank_d = rd_bank_q;
      pend_d    = pend_q;
      case (state_q)
         IDLE: begin
            if (blk_done) begin
               state_d   = DRAIN;
               rd_beat_d = '0;
            end
         end
         DRAIN: begin
            if (rd_beat_q == LAST_BEAT) begin
               rd_beat_d = '0;
               rd_bank_d = ~rd_bank_q;
               pend_d    = 1'b0;
               state_d   = (blk_done || pend_q) ? DRAIN : IDLE;
            end else begin
               rd_beat_d = rd_beat_q + 1'b1;
               if (blk_done) pend_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign drain = (state_q == DRAIN);

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         y_re[k] = norm(mem_re_q[rd_bank_q][rd_beat_q][k], exp_bank_q[rd_bank_q]);
         y_im[k] = norm(mem_im_q[rd_bank_q][rd_beat_q][k], exp_bank_q[rd_bank_q]);
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q   <= 1'b0;
         sob1_q <= 1'b0;
         exp1_q <= '0;
         re1_q  <= '0;
         im1_q  <= '0;
      end else begin
         v1_q   <= drain;
         sob1_q <= drain && (rd_beat_q == '0);
         if (drain) begin
            exp1_q <= exp_bank_q[rd_bank_q];
            re1_q  <= y_re;
            im1_q  <= y_im;
         end
      end
   end

`ifdef CBFP_ROUND_EN
   logic                        v2_q, sob2_q;
   logic [EXP_W-1:0]            exp2_q;
   logic [LANES-1:0][OUT_W-1:0] re2_q, im2_q;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v2_q   <= 1'b0;
         sob2_q <= 1'b0;
         exp2_q <= '0;
         re2_q  <= '0;
         im2_q  <= '0;
      end else begin
         v2_q   <= v1_q;
         sob2_q <= sob1_q;
         if (v1_q) begin
            exp2_q <= exp1_q;
            re2_q  <= re1_q;
            im2_q  <= im1_q;
         end
      end
   end

   assign valid_out = v2_q;
   assign sob_out   = sob2_q;
   assign exp_out   = exp2_q;
   assign dout_re   = re2_q;
   assign dout_im   = im2_q;
`else
   assign valid_out = v1_q;
   assign sob_out   = sob1_q;
   assign exp_out   = exp1_q;
   assign dout_re   = re1_q;
   assign dout_im   = im1_q;
`endif

endmodule

// File: doc/cbfp_stage.md
# cbfp_stage

Parametrised convergent block-floating-point normaliser, the generalised successor of the fixed 64-point, 16-lane CBFP stage between FFT butterfly modules. It accepts `LANES` complex samples per beat, groups `BLK_LEN` samples into a block, and computes one shared exponent per block from the minimum redundant-sign-bit count over both real and imaginary parts. It then re-emits the block shifted and narrowed to `OUT_W` bits, with the exponent attached, and sustains full streaming throughput through a ping-pong buffer.

## Interface
- `IN_W`, 23: input sample width (signed two's complement).
- `OUT_W`, 11: output sample width; `OUT_W < IN_W`.
- `LANES`, 16: complex samples per beat.
- `BLK_LEN`, 64: samples per block; must be a multiple of `LANES`. `BEATS = BLK_LEN/LANES` (≥1).
- `MAX_SHIFT`, `IN_W-OUT_W`: upper clamp on the block exponent.
- `EXP_W`, `$clog2(IN_W)`: exponent width.
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous and active-low.
- `valid_in` in 1: input beat qualifier; gaps allowed.
- `din_re`, `din_im` in `[IN_W-1:0]` × `LANES`: input samples; lane k is block sample `beat*LANES+k`.
- `valid_out` out 1: output beat qualifier.
- `sob_out` out 1: high on the first output beat of a block.
- `exp_out` out `EXP_W`: block exponent; stable for all beats of the block.
- `dout_re`, `dout_im` out `[OUT_W-1:0]` × `LANES`: normalised samples.

## Operation
- Redundant sign bits r(x): the number of bits below the MSB equal to the MSB, range 0..`IN_W-1`. Examples: r(0) = `IN_W-1`, r(-1) = `IN_W-1`, r(-2^(IN_W-1)) = 0.
- Fill side:
  - Beat counter `wr_beat` runs 0..`BEATS-1` and bank select `wr_bank` is 0/1.
  - Each accepted beat is written to `bank[wr_bank][wr_beat]`.
  - A running minimum of r over all 2×`LANES` values is kept, restarting at beat 0.
  - On the last beat, e = min(running_min, `MAX_SHIFT`) is latched into that bank's exponent register, `wr_bank` toggles, and `wr_beat` wraps to 0.
- Drain FSM, states IDLE and DRAIN:
  - IDLE→DRAIN on a block-complete event. DRAIN emits one beat per cycle, beat 0..`BEATS-1`, unconditionally; `valid_in` gaps do not stall it.
  - At the last drain beat: go to DRAIN (other bank, beat 0) if a block-complete event occurs in that same cycle or is pending; otherwise go to IDLE.
- Output arithmetic:
  - y = (x <<< e) >>> (`IN_W-OUT_W`), with truncation toward −∞.
  - Because e ≤ r(x), the left shift never overflows.
  - The result always fits `OUT_W` when `MAX_SHIFT ≤ IN_W-OUT_W`.
- Two banks always suffice: a fill takes ≥`BEATS` cycles and a drain takes exactly `BEATS` cycles. No overflow condition exists, so there is no ready signal.
- Reset mid-block: the partial block is discarded and the FSM returns to IDLE.

## Timing
- Reset values:
  - `valid_out` = 0, `sob_out` = 0, `exp_out` = 0, all `dout` = 0.
  - Counters, bank select and the running minimum reset to 0 / `IN_W-1`.
- Latency: if the last input beat of a block is sampled at edge t, output beat k is registered at edge t+1+k, with `valid_out` high and `sob_out` high for k = 0 only.
- Back-to-back blocks with contiguous input produce contiguous `valid_out`, with no bubble between blocks.
- `exp_out` updates together with `sob_out` and holds until the next block's beat 0.
- When `valid_out` is 0, the `dout` and `exp_out` values are held at their last values.

## Configuration
- `CBFP_ROUND_EN` defined:
  - Add 2^(`IN_W-OUT_W-1`) to (x <<< e) before the right shift, i.e. round half up.
  - Saturate the result to [−2^(`OUT_W-1`), 2^(`OUT_W-1`)−1].
  - Adds one output register stage, so every latency above grows by 1 cycle.
- Not defined: pure truncation, no saturation logic, latency as stated.

## Test plan
All cases use default parameters unless stated.
- **Max-shift case.** One block, all lanes 1, one lane 1000 → e=12 (clamped); outputs 1 and 1000; `sob_out` on beat 0 at t+1.
- **Shift of one.** Block containing 2^20 and −3, others 0 → e=1; outputs 512, and −1 for −3 (truncation); with `CBFP_ROUND_EN`, outputs 512 and 0 one cycle later.
- **Extreme values.** All-zero block → e=12, all outputs 0. A block containing −2^22 → e=0, output −1024.
- **Continuous stream.** Four contiguous blocks with distinct exponents (0, 3, 7, 12) → `valid_out` continuous for 16 beats, correct `exp_out` per block, no bubbles.
- **Gapped input.** `valid_in` toggling 1/0 → per-block output still emitted as 4 contiguous beats, with data identical to the gap-free run.
- **Reset mid-stream.** Assert `rstn`=0 after beat 2 of a block, then release → all outputs 0 at once. The next full block is output correctly, with no residue from the partial block.
